cyclic_sr_seq_ctrl: RTL and testbench

Sequencing controller that drives the load/shift inputs of the team's 4-bit cyclic shift register (active-low load enable, rotate-left on shift). It accepts a rotation job (start pattern plus step count) over a valid/ready handshake, loads the pattern, and issues exactly the requested number of rotate strobes at a programmable rate. Between strobes it holds the downstream register by reloading its current value, because that register has no hold mode. It keeps a mirror of the register contents and pulses `done` when the job finishes.

---
 rtl/cyclic_sr_seq_ctrl.sv | 113 +++++++++++
 tb/tb_cyclic_sr_seq_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cyclic_sr_seq_ctrl.sv
// Purpose : sequences load/rotate strobes into a 4-bit cyclic shift register (en=0 load, en=1 rotate-left).
// Latency : handshake at edge 0 -> LOAD cycle 1, strobe k in cycle 1+k*DIV, done in cycle 2+N*DIV, idle in 3+N*DIV.
// Backpr. : req_ready only in IDLE; requests outside IDLE are ignored, never queued.
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   req_valid/req_ready   job handshake; req_pattern = start pattern, req_steps = rotate count
//   sr_d, sr_en           drive the shift register's D and en (Moore, no path from req_*)
//   sr_mirror             copy of the register contents
//   busy, done            job in progress; one-cycle pulse at job end
module cyclic_sr_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int STEPW = 4,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_pattern,
  input  logic [STEPW-1:0] req_steps,
  output logic [WIDTH-1:0] sr_d,
  output logic             sr_en,
  output logic [WIDTH-1:0] sr_mirror,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam logic [7:0]       DIV_LAST = 8'(DIV - 1);
  localparam logic [STEPW-1:0] REM_ONE  = STEPW'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q;
  logic [WIDTH-1:0] mirror_q;
  logic [STEPW-1:0] rem_q;
  logic [7:0]       div_q;
  logic             strobe;
  logic             handshake;
  logic [WIDTH-1:0] rotated;

  assign strobe    = (state_q == SHIFT) && (div_q == DIV_LAST);
  assign handshake = req_valid && (state_q == IDLE);
  assign rotated   = {mirror_q[WIDTH-2:0], mirror_q[WIDTH-1]};
  assign sr_mirror = mirror_q;

  // The downstream register has no hold mode, so every non-strobe cycle
  // reloads it with its own current value (the mirror).
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    sr_en     = 1'b0;
    sr_d      = mirror_q;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_d = LOAD;
      end
      LOAD: begin
        sr_d    = pat_q;
        state_d = (rem_q == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (strobe) begin
          sr_en = 1'b1;
          if (rem_q == REM_ONE) state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      pat_q    <= '0;
      mirror_q <= '0;
      rem_q    <= '0;
      div_q    <= '0;
    end else begin
      state_q <= state_d;
      if (handshake) begin
        pat_q <= req_pattern;
        rem_q <= req_steps;
      end
      case (state_q)
        LOAD: begin
          mirror_q <= pat_q;
          div_q    <= '0;
        end
        SHIFT: begin
          if (strobe) begin
            mirror_q <= rotated;
            rem_q    <= rem_q - REM_ONE;
            div_q    <= '0;
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cyclic_sr_seq_ctrl.sv
module tb_cyclic_sr_seq_ctrl;

  logic       clk;
  logic       reset;
  logic       rv [2];
  logic [3:0] rp [2];
  logic [3:0] rs [2];
  logic       rr [2];
  logic [3:0] sd [2];
  logic       se [2];
  logic [3:0] sm [2];
  logic       bz [2];
  logic       dn [2];
  logic [3:0] mdl [2];
  logic [3:0] last_mir [2];
  int         divv [2];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       en;
    logic       chk_d;
    logic [3:0] d;
    logic [3:0] mir;
    logic       busy;
    logic       done;
    logic       rdy;
  } exp_t;

  typedef struct {
    int         sel;
    logic [3:0] pat;
    logic [3:0] steps;
    logic [3:0] fin;
    bit         hold;
  } job_t;

  exp_t exp_q[$];
  job_t jobs[7];

  cyclic_sr_seq_ctrl #(.WIDTH(4), .STEPW(4), .DIV(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(rv[0]), .req_ready(rr[0]),
    .req_pattern(rp[0]), .req_steps(rs[0]), .sr_d(sd[0]), .sr_en(se[0]),
    .sr_mirror(sm[0]), .busy(bz[0]), .done(dn[0])
  );

  cyclic_sr_seq_ctrl #(.WIDTH(4), .STEPW(4), .DIV(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(rv[1]), .req_ready(rr[1]),
    .req_pattern(rp[1]), .req_steps(rs[1]), .sr_d(sd[1]), .sr_en(se[1]),
    .sr_mirror(sm[1]), .busy(bz[1]), .done(dn[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model of the downstream cyclic shift register.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset)      mdl[i] <= 4'b0000;
      else if (!se[i]) mdl[i] <= sd[i];
      else             mdl[i] <= {mdl[i][2:0], mdl[i][3]};
    end
  end

  function automatic logic [3:0] rotl(input logic [3:0] v, input int n);
    logic [3:0] r;
    r = v;
    for (int i = 0; i < (n % 4); i++) r = {r[2:0], r[3]};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, expv);
    end
  endtask

  task automatic chk_idle_reset(input int sel, input string tag);
    chk($sformatf("%s_en%0d", tag, sel), 32'(se[sel]), 0);
    chk($sformatf("%s_d%0d", tag, sel), 32'(sd[sel]), 0);
    chk($sformatf("%s_mir%0d", tag, sel), 32'(sm[sel]), 0);
    chk($sformatf("%s_rdy%0d", tag, sel), 32'(rr[sel]), 1);
    chk($sformatf("%s_busy%0d", tag, sel), 32'(bz[sel]), 0);
    chk($sformatf("%s_done%0d", tag, sel), 32'(dn[sel]), 0);
  endtask

  // Drives one job from a negedge in IDLE; expected cycle trace is pushed up
  // front from the latency formulas and popped once per cycle after the edge.
  task automatic run_job(input int sel, input logic [3:0] p, input logic [3:0] n,
                         input logic [3:0] fin, input bit hold);
    exp_t e;
    int   d, ni, len;
    d   = divv[sel];
    ni  = int'(n);
    len = 3 + ni * d;
    for (int c = 1; c <= len; c++) begin
      e.en = 1'b0; e.chk_d = 1'b1; e.busy = 1'b1; e.done = 1'b0; e.rdy = 1'b0;
      if (c == 1) begin
        e.d = p; e.mir = last_mir[sel];
      end else if (c <= 1 + ni * d) begin
        e.mir = rotl(p, (c - 2) / d); e.d = e.mir;
        if (((c - 1) % d) == 0) begin e.en = 1'b1; e.chk_d = 1'b0; end
      end else if (c == 2 + ni * d) begin
        e.mir = rotl(p, ni); e.d = e.mir; e.done = 1'b1;
      end else begin
        e.mir = rotl(p, ni); e.d = e.mir; e.busy = 1'b0; e.rdy = 1'b1;
      end
      exp_q.push_back(e);
    end
    rv[sel] = 1'b1; rp[sel] = p; rs[sel] = n;
    @(posedge clk);
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (hold) begin rp[sel] = 4'b0101; rs[sel] = 4'd1; end
        else rv[sel] = 1'b0;
      end
      e = exp_q.pop_front();
      chk($sformatf("p%0h_n%0d_c%0d_en", p, ni, c), 32'(se[sel]), 32'(e.en));
      if (e.chk_d) chk($sformatf("p%0h_n%0d_c%0d_d", p, ni, c), 32'(sd[sel]), 32'(e.d));
      chk($sformatf("p%0h_n%0d_c%0d_mir", p, ni, c), 32'(sm[sel]), 32'(e.mir));
      chk($sformatf("p%0h_n%0d_c%0d_busy", p, ni, c), 32'(bz[sel]), 32'(e.busy));
      chk($sformatf("p%0h_n%0d_c%0d_done", p, ni, c), 32'(dn[sel]), 32'(e.done));
      chk($sformatf("p%0h_n%0d_c%0d_rdy", p, ni, c), 32'(rr[sel]), 32'(e.rdy));
      chk($sformatf("p%0h_n%0d_c%0d_model", p, ni, c), 32'(mdl[sel]), 32'(sm[sel]));
      if (c == len - 1) chk($sformatf("p%0h_n%0d_final", p, ni), 32'(sm[sel]), 32'(fin));
    end
    last_mir[sel] = fin;
  endtask

  initial begin : main
    int  waited;
    bit  seen;

    divv[0] = 1; divv[1] = 3;
    jobs[0] = '{0, 4'b0001, 4'd3,  4'b1000, 1'b0};
    jobs[1] = '{0, 4'b1010, 4'd0,  4'b1010, 1'b0};
    jobs[2] = '{1, 4'b1001, 4'd2,  4'b0110, 1'b0};
    jobs[3] = '{0, 4'b1100, 4'd4,  4'b1100, 1'b1};
    jobs[4] = '{0, 4'b0110, 4'd1,  4'b1100, 1'b0};
    jobs[5] = '{1, 4'b0001, 4'd5,  4'b0010, 1'b0};
    jobs[6] = '{0, 4'b1011, 4'd15, 4'b1101, 1'b0};

    // Reset held for three edges with a request pending on both controllers.
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b1; rp[i] = 4'b1111; rs[i] = 4'd5; last_mir[i] = 4'b0000;
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk_idle_reset(0, $sformatf("rst%0d", k));
      chk_idle_reset(1, $sformatf("rst%0d", k));
    end
    reset = 1'b1;
    rv[0] = 1'b0; rv[1] = 1'b0;
    @(negedge clk);
    chk("post_rst_busy0", 32'(bz[0]), 0);
    chk("post_rst_busy1", 32'(bz[1]), 0);

    for (int j = 0; j < 7; j++) begin
      run_job(jobs[j].sel, jobs[j].pat, jobs[j].steps, jobs[j].fin, jobs[j].hold);
      if (jobs[j].hold) begin
        // Second request stayed asserted for the whole job; it lands only now.
        chk("hold_idle_rdy", 32'(rr[0]), 1);
        @(negedge clk);
        rv[0] = 1'b0;
        chk("hold2_busy", 32'(bz[0]), 1);
        chk("hold2_load_d", 32'(sd[0]), 32'(4'b0101));
        chk("hold2_rdy", 32'(rr[0]), 0);
        waited = 0; seen = 1'b0;
        while (!seen && waited < 20) begin
          @(negedge clk);
          waited++;
          if (dn[0]) seen = 1'b1;
        end
        chk("hold2_done_seen", 32'(seen), 1);
        chk("hold2_mir", 32'(sm[0]), 32'(4'b1010));
        @(negedge clk);
        chk("hold2_back_idle", 32'(rr[0]), 1);
        last_mir[0] = 4'b1010;
      end
    end

    // Reset during SHIFT: DIV=1, pattern 0011, 8 steps, reset sampled at end of cycle 4.
    rv[0] = 1'b1; rp[0] = 4'b0011; rs[0] = 4'd8;
    @(posedge clk);
    @(negedge clk);
    rv[0] = 1'b0;
    chk("mid_c1_d", 32'(sd[0]), 32'(4'b0011));
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("mid_c4_en", 32'(se[0]), 1);
    chk("mid_c4_mir", 32'(sm[0]), 32'(4'b1100));
    reset = 1'b0;
    @(negedge clk);
    chk_idle_reset(0, "mid_c5");
    chk("mid_c5_model", 32'(mdl[0]), 0);
    reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("mid_after%0d_done", k), 32'(dn[0]), 0);
      chk($sformatf("mid_after%0d_busy", k), 32'(bz[0]), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
